// File: rtl/mdu_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  // The four multi-cycle ops are exactly the funct codes 0110xx.
  function automatic logic is_muldiv(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/mdu_shift_core.sv
// Iterative datapath: shift-add multiply or restoring divide, one bit per step,
// on unsigned magnitudes. Mode is captured from is_div on each step/load.
module mdu_shift_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic                 is_div,
  input  logic [WIDTH-1:0]     opnd_a,
  input  logic [WIDTH-1:0]     opnd_b,
  output logic [2*WIDTH-1:0]   acc,
  output logic                 last
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   opnd;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     add, rem_sh, diff;
  logic [2*WIDTH-1:0] acc_nx;

  always_comb begin
    add    = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd})
                    : {1'b0, acc[2*WIDTH-1:WIDTH]};
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, opnd};
    // A borrow out of the (WIDTH+1)-bit subtract means the divisor did not fit.
    if (is_div) begin
      if (!diff[WIDTH]) acc_nx = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else              acc_nx = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_nx = {add, acc[WIDTH-1:1]};
    end
    last = (cnt == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc  <= '0;
      opnd <= '0;
      cnt  <= '0;
    end else if (load) begin
      opnd <= is_div ? opnd_b : opnd_a;
      acc  <= {{WIDTH{1'b0}}, (is_div ? opnd_a : opnd_b)};
      cnt  <= CW'(WIDTH - 1);
    end else if (step) begin
      acc  <= acc_nx;
      cnt  <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// MIPS multiply/divide unit: FSM, sign handling and the architectural HI/LO.
//   state  | meaning
//   S_IDLE | waiting for start
//   S_MUL  | shift-add iterations
//   S_DIV  | restoring-divide iterations
//   S_FIX  | sign correction, HI/LO write
//   S_DONE | done pulse; accepts start like S_IDLE
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t             state;
  logic               op_div, neg_res, neg_rem, zero_div;
  logic [WIDTH-1:0]   a_raw;
  logic               take, is_md, is_dv, b_zero, a_neg, b_neg;
  logic               load, step, is_div, last;
  logic [WIDTH-1:0]   a_abs, b_abs, quo, rem;
  logic [2*WIDTH-1:0] acc, prod;

  always_comb begin
    take   = start && (state == S_IDLE || state == S_DONE);
    is_md  = is_muldiv(func);
    is_dv  = func[1];
    b_zero = (b == '0);
    a_neg  = ~func[0] & a[WIDTH-1];
    b_neg  = ~func[0] & b[WIDTH-1];
    a_abs  = a_neg ? -a : a;
    b_abs  = b_neg ? -b : b;
    load   = take && is_md && !(is_dv && b_zero);
    step   = (state == S_MUL) || (state == S_DIV);
    is_div = load ? is_dv : (state == S_DIV);
    quo    = acc[WIDTH-1:0];
    rem    = acc[2*WIDTH-1:WIDTH];
    prod   = neg_res ? -acc : acc;
  end

  mdu_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .is_div (is_div),
    .opnd_a (a_abs),
    .opnd_b (b_abs),
    .acc    (acc),
    .last   (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div0     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      op_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      zero_div <= 1'b0;
      a_raw    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (take && is_md) begin
            busy     <= 1'b1;
            div0     <= 1'b0;
            op_div   <= is_dv;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            zero_div <= is_dv && b_zero;
            a_raw    <= a;
            if (is_dv && b_zero) state <= S_FIX;
            else if (is_dv)      state <= S_DIV;
            else                 state <= S_MUL;
          end else if (take && func == F_MTHI) begin
            hi   <= a;
            div0 <= 1'b0;
          end else if (take && func == F_MTLO) begin
            lo   <= a;
            div0 <= 1'b0;
          end
        end
        S_MUL, S_DIV: begin
          if (last) state <= S_FIX;
        end
        S_FIX: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
          if (zero_div) begin
            hi   <= a_raw;
            lo   <= '1;
            div0 <= 1'b1;
          end else if (op_div) begin
            lo <= neg_res ? -quo : quo;
            hi <= neg_rem ? -rem : rem;
          end else begin
            {hi, lo} <= prod;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed ops push expected HI/LO/div0,
// a monitor pops and compares on every done pulse.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk, rst, start, busy, done, div0;
  logic [5:0]  func;
  logic [31:0] a, b, hi, lo;

  typedef struct {
    string       nm;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .func  (func),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .div0  (div0),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL extra_done: got done=1 expected no done (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk({e.nm, "_hi"}, 64'(hi), 64'(e.hi));
        chk({e.nm, "_lo"}, 64'(lo), 64'(e.lo));
        chk({e.nm, "_div0"}, 64'(div0), 64'(e.dz));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic start_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; func = f; a = x; b = y;
    cyc = 0;
    tick();
    start = 1'b0; func = 6'd0; a = '0; b = '0;
  endtask

  task automatic wait_done(input string nm, input int exp_lat);
    while (done !== 1'b1 && cyc < 200) tick();
    chk({nm, "_latency"}, 64'(cyc), 64'(exp_lat));
    chk({nm, "_busy_at_done"}, 64'(busy), 64'd0);
  endtask

  task automatic run_op(input string nm, input logic [5:0] f, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz, input int elat);
    exp_t t;
    t.nm = nm; t.hi = ehi; t.lo = elo; t.dz = edz;
    sb.push_back(t);
    start_op(f, x, y);
    chk({nm, "_busy_rise"}, 64'(busy), 64'd1);
    chk({nm, "_div0_clear"}, 64'(div0), 64'd0);
    wait_done(nm, elat);
  endtask

  initial begin
    exp_t t;
    rst = 1'b1; start = 1'b0; func = 6'd0; a = '0; b = '0;
    #1 rst = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_div0", 64'(div0), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tick();

    run_op("mult_neg", F_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34);
    run_op("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34);
    run_op("mult_negneg", F_MULT, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h0, 32'h1E, 1'b0, 34);
    run_op("multu_msb", F_MULTU, 32'h80000000, 32'd2, 32'h1, 32'h0, 1'b0, 34);
    run_op("div_neg", F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
    run_op("divu", F_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 34);
    run_op("div_ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 34);
    run_op("div_posneg", F_DIV, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 1'b0, 34);
    run_op("div_negpos", F_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0, 34);
    run_op("divu_zero", F_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 2);
    run_op("mult_after_dz", F_MULT, 32'h12345, 32'h100, 32'h0, 32'h01234500, 1'b0, 34);
    run_op("div_zero", F_DIV, 32'hFFFFFFF7, 32'd0, 32'hFFFFFFF7, 32'hFFFFFFFF, 1'b1, 2);

    // MTHI while a MULT is in flight must be ignored.
    repeat (2) tick();
    t.nm = "mult_mthi_busy"; t.hi = 32'h1; t.lo = 32'h0; t.dz = 1'b0;
    sb.push_back(t);
    start_op(F_MULT, 32'h10000, 32'h10000);
    repeat (4) tick();
    start = 1'b1; func = F_MTHI; a = 32'h1234;
    tick();
    start = 1'b0; func = 6'd0; a = '0;
    wait_done("mult_mthi_busy", 34);
    repeat (4) tick();

    // MTLO / MTHI / unknown funct while idle.
    start_op(F_MTLO, 32'hABCD, 32'h0);
    chk("mtlo_lo", 64'(lo), 64'h0000ABCD);
    chk("mtlo_hi_kept", 64'(hi), 64'h1);
    chk("mtlo_busy", 64'(busy), 64'd0);
    chk("mtlo_done", 64'(done), 64'd0);
    tick();
    chk("mtlo_done_late", 64'(done), 64'd0);
    start_op(F_MTHI, 32'h5555, 32'h0);
    chk("mthi_hi", 64'(hi), 64'h5555);
    chk("mthi_busy", 64'(busy), 64'd0);
    start_op(6'b100000, 32'h7777, 32'h8888);
    chk("unk_hilo", {hi, lo}, 64'h00005555_0000ABCD);
    chk("unk_busy", 64'(busy), 64'd0);
    tick();

    // Back-to-back: second op is accepted in the DONE cycle of the first.
    run_op("b2b_first", F_MULT, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0, 34);
    run_op("b2b_second", F_MULT, 32'd7, 32'd8, 32'h0, 32'd56, 1'b0, 34);
    run_op("multu_pre_rst", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0, 34);

    // Asynchronous reset in the middle of a divide.
    start_op(F_DIVU, 32'd1000, 32'd3);
    repeat (9) tick();
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_div0", 64'(div0), 64'd0);
    chk("midrst_hilo", {hi, lo}, 64'd0);
    tick();
    rst = 1'b1;
    tick();
    run_op("divu_after_rst", F_DIVU, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, 34);
    repeat (3) tick();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
